// File: rtl/sevenseg_decoder_pkg.sv
// Shared constants for the seven-segment decoder: active-low segment codes,
// FSM state encoding and accumulator width.
package sevenseg_decoder_pkg;

    // Active-low segment codes for digits 0..9 (bit 7 is the decimal point, off = 1)
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;

    // Four decimal digits reach at most 9999, which fits in 14 bits without wrapping
    localparam int ACC_WIDTH = 14;

    typedef enum logic [2:0] {
        SDEC_IDLE = 3'd0,
        SDEC_D3   = 3'd1,
        SDEC_D2   = 3'd2,
        SDEC_D1   = 3'd3,
        SDEC_D0   = 3'd4,
        SDEC_DONE = 3'd5
    } sdec_state_t;

endpackage

// File: rtl/sevenseg_digit_decoder.sv
// Combinational decode of one active-low segment byte into a decimal digit.
// Any pattern outside the ten legal codes (including a lit decimal point)
// reports valid = 0.
module sevenseg_digit_decoder
    import sevenseg_decoder_pkg::*;
(
    input  logic [7:0] seg_byte,
    output logic       valid,
    output logic [3:0] digit
);

    // Map each legal segment code to its digit; everything else is invalid
    always_comb begin
        valid = 1'b1;
        digit = 4'd0;
        case (seg_byte)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_decoder.sv
// Sequential seven-segment word to binary converter. A captured 32-bit word
// (thousands byte first) is walked one digit per cycle with acc = acc*10 + d.
// Illegal bytes abort early; results above 255 are flagged and not loaded.
module sevenseg_decoder
    import sevenseg_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        async_reset,
    input  logic        start,
    input  logic [31:0] data_input_sevensegs,
    output logic        busy,
    output logic        done,
    output logic [7:0]  data_output,
    output logic        error_invalid,
    output logic        error_overflow
);

    sdec_state_t state;
    sdec_state_t next_state;

    logic [31:0]          word_reg;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_mac;
    logic [7:0]           cur_byte;
    logic                 digit_valid;
    logic [3:0]           digit;

    logic load;
    logic acc_en;
    logic set_invalid;
    logic finish;

    // Pick the byte belonging to the digit state currently being processed
    always_comb begin
        cur_byte = word_reg[7:0];
        case (state)
            SDEC_D3: cur_byte = word_reg[31:24];
            SDEC_D2: cur_byte = word_reg[23:16];
            SDEC_D1: cur_byte = word_reg[15:8];
            SDEC_D0: cur_byte = word_reg[7:0];
            default: cur_byte = word_reg[7:0];
        endcase
    end

    sevenseg_digit_decoder u_digit (
        .seg_byte (cur_byte),
        .valid    (digit_valid),
        .digit    (digit)
    );

    // acc*10 as two shifts; acc is at most 999 whenever it is multiplied
    assign acc_mac = (acc << 3) + (acc << 1) + {{(ACC_WIDTH-4){1'b0}}, digit};

    // State register
    always_ff @(posedge clk) begin
        if (async_reset) begin
            state <= SDEC_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the datapath strobes that go with each transition
    always_comb begin
        next_state  = state;
        load        = 1'b0;
        acc_en      = 1'b0;
        set_invalid = 1'b0;
        finish      = 1'b0;
        case (state)
            SDEC_IDLE: begin
                if (start) begin
                    next_state = SDEC_D3;
                    load       = 1'b1;
                end
            end
            SDEC_D3, SDEC_D2, SDEC_D1, SDEC_D0: begin
                if (!digit_valid) begin
                    next_state  = SDEC_DONE;
                    set_invalid = 1'b1;
                end else begin
                    acc_en = 1'b1;
                    case (state)
                        SDEC_D3: next_state = SDEC_D2;
                        SDEC_D2: next_state = SDEC_D1;
                        SDEC_D1: next_state = SDEC_D0;
                        default: begin
                            next_state = SDEC_DONE;
                            finish     = 1'b1;
                        end
                    endcase
                end
            end
            SDEC_DONE: next_state = SDEC_IDLE;
            default:   next_state = SDEC_IDLE;
        endcase
    end

    // Word capture, accumulator and registered outputs; outputs reflect the
    // state being entered so done/busy/result line up with the DONE cycle
    always_ff @(posedge clk) begin
        if (async_reset) begin
            word_reg       <= '0;
            acc            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            data_output    <= '0;
            error_invalid  <= 1'b0;
            error_overflow <= 1'b0;
        end else begin
            busy <= (next_state != SDEC_IDLE);
            done <= (next_state == SDEC_DONE);
            if (load) begin
                word_reg       <= data_input_sevensegs;
                acc            <= '0;
                error_invalid  <= 1'b0;
                error_overflow <= 1'b0;
            end
            if (acc_en) begin
                acc <= acc_mac;
            end
            if (set_invalid) begin
                error_invalid <= 1'b1;
            end
            if (finish) begin
                if (acc_mac > ACC_WIDTH'(255)) begin
                    error_overflow <= 1'b1;
                end else begin
                    data_output <= acc_mac[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_decoder.sv
// Self-checking bench for sevenseg_decoder: a table of directed conversions
// followed by hand-written sequences for ignored starts and mid-run reset.
module tb_sevenseg_decoder;

    logic        clk;
    logic        async_reset;
    logic        start;
    logic [31:0] data_input_sevensegs;
    logic        busy;
    logic        done;
    logic [7:0]  data_output;
    logic        error_invalid;
    logic        error_overflow;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  exp_out;
        logic        exp_inv;
        logic        exp_ovf;
        int          exp_cycle;
    } vec_t;

    vec_t vecs[9];

    sevenseg_decoder dut (
        .clk                  (clk),
        .async_reset          (async_reset),
        .start                (start),
        .data_input_sevensegs (data_input_sevensegs),
        .busy                 (busy),
        .done                 (done),
        .data_output          (data_output),
        .error_invalid        (error_invalid),
        .error_overflow       (error_overflow)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Present a word with a one-cycle start; returns #1 after the accepting edge (cycle 1)
    task automatic applyStimulus(input logic [31:0] w);
        @(negedge clk);
        data_input_sevensegs = w;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Run one table entry and compare latency, busy, result and flags
    task automatic runVector(input vec_t v, input int idx);
        int cyc;
        logic busy_ok;
        applyStimulus(v.word);
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 20) begin
            if (!busy) busy_ok = 1'b0;
            stepCycle();
            cyc++;
        end
        checkOutput($sformatf("vec%0d done_cycle", idx), cyc, v.exp_cycle);
        checkOutput($sformatf("vec%0d busy_before_done", idx), {31'd0, busy_ok}, 32'd1);
        checkOutput($sformatf("vec%0d busy_at_done", idx), {31'd0, busy}, 32'd1);
        checkOutput($sformatf("vec%0d data_output", idx), {24'd0, data_output}, {24'd0, v.exp_out});
        checkOutput($sformatf("vec%0d error_invalid", idx), {31'd0, error_invalid}, {31'd0, v.exp_inv});
        checkOutput($sformatf("vec%0d error_overflow", idx), {31'd0, error_overflow}, {31'd0, v.exp_ovf});
        stepCycle();
        checkOutput($sformatf("vec%0d done_after", idx), {31'd0, done}, 32'd0);
        checkOutput($sformatf("vec%0d busy_after", idx), {31'd0, busy}, 32'd0);
    endtask

    // Test sequence
    initial begin
        int done_cnt;
        int cyc;
        tests_run            = 0;
        tests_failed         = 0;
        async_reset          = 1'b1;
        start                = 1'b0;
        data_input_sevensegs = 32'h0;

        vecs[0] = '{32'hC0C0A4F9, 8'd21,  1'b0, 1'b0, 5};
        vecs[1] = '{32'hC0A49292, 8'd255, 1'b0, 1'b0, 5};
        vecs[2] = '{32'hC0A49282, 8'd255, 1'b0, 1'b1, 5};
        vecs[3] = '{32'hC0C0FFF9, 8'd255, 1'b1, 1'b0, 4};
        vecs[4] = '{32'h40C0C0C0, 8'd255, 1'b1, 1'b0, 2};
        vecs[5] = '{32'hF9A4B099, 8'd255, 1'b0, 1'b1, 5};
        vecs[6] = '{32'hC0C0C0C0, 8'd0,   1'b0, 1'b0, 5};
        vecs[7] = '{32'hC0C09990, 8'd49,  1'b0, 1'b0, 5};
        vecs[8] = '{32'h90909090, 8'd49,  1'b0, 1'b1, 5};

        stepCycle();
        stepCycle();
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset data_output", {24'd0, data_output}, 32'd0);
        checkOutput("reset error_invalid", {31'd0, error_invalid}, 32'd0);
        checkOutput("reset error_overflow", {31'd0, error_overflow}, 32'd0);
        async_reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            runVector(vecs[i], i);
        end

        // Starts at cycles 2 and 5 ignored; start at cycle 6 accepted and clears flags
        applyStimulus(32'hC0A49282);
        done_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            if (done) done_cnt++;
            if (c == 5) begin
                checkOutput("ignore overflow_at_done", {31'd0, error_overflow}, 32'd1);
            end
            if (c == 2 || c == 5) begin
                start = 1'b1;
                data_input_sevensegs = 32'hFFFFFFFF;
            end else if (c == 6) begin
                start = 1'b1;
                data_input_sevensegs = 32'hC0C0A4F9;
            end else begin
                start = 1'b0;
            end
            stepCycle();
        end
        start = 1'b0;
        data_input_sevensegs = 32'hFFFFFFFF;
        checkOutput("ignore done_pulses", done_cnt, 1);
        checkOutput("restart busy", {31'd0, busy}, 32'd1);
        checkOutput("restart flags_cleared", {30'd0, error_invalid, error_overflow}, 32'd0);
        checkOutput("restart data_held", {24'd0, data_output}, 32'd49);
        cyc = 1;
        while (!done && cyc < 20) begin
            stepCycle();
            cyc++;
        end
        checkOutput("restart done_cycle", cyc, 5);
        checkOutput("restart data_output", {24'd0, data_output}, 32'd21);
        checkOutput("restart errors", {30'd0, error_invalid, error_overflow}, 32'd0);
        stepCycle();

        // Reset sampled at edge 3 of a conversion returns everything to zero
        applyStimulus(32'hC0C0F9A4);
        stepCycle();
        async_reset = 1'b1;
        stepCycle();
        async_reset = 1'b0;
        checkOutput("midreset busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset data_output", {24'd0, data_output}, 32'd0);
        checkOutput("midreset flags", {30'd0, error_invalid, error_overflow}, 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) done_cnt++;
            stepCycle();
        end
        checkOutput("midreset no_done", done_cnt, 0);

        // Reset together with start: reset wins, nothing starts
        @(negedge clk);
        async_reset = 1'b1;
        start = 1'b1;
        data_input_sevensegs = 32'hC0C0A4F9;
        stepCycle();
        async_reset = 1'b0;
        start = 1'b0;
        checkOutput("reset_with_start busy", {31'd0, busy}, 32'd0);
        stepCycle();
        checkOutput("reset_with_start idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
